demux_8_tdm: RTL and testbench

DEMUX_8_TDM -- requirements
Module: demux_8_tdm

---
 rtl/demux_8_tdm.sv | 62 ++++++
 tb/tb_demux_8_tdm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/demux_8_tdm.sv
// demux_8_tdm: 1-to-8 TDM demultiplexer with frame-sync hunting and alignment checking.
module demux_8_tdm #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [8*W-1:0] dout,
    output logic           dout_valid,
    output logic [2:0]     slot,
    output logic           locked,
    output logic           sync_err
);
    typedef enum logic {HUNT, RUN} state_t;
    state_t              state_q;
    logic [6:0][W-1:0]   shadow_q;
    logic [2:0]          slot_q;
    logic [8*W-1:0]      dout_q;
    logic                dout_valid_q;
    logic                sync_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            slot_q       <= 3'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (din_valid) begin
                if (frame_sync) begin
                    // a sync mid-frame restarts the frame; stale shadow words get overwritten before use
                    sync_err_q  <= (state_q == RUN) && (slot_q != 3'd0);
                    shadow_q[0] <= din;
                    slot_q      <= 3'd1;
                    state_q     <= RUN;
                end else if (state_q == RUN) begin
                    if (slot_q == 3'd0) begin
                        sync_err_q <= 1'b1;
                        state_q    <= HUNT;
                    end else if (slot_q == 3'd7) begin
                        dout_q       <= {din, shadow_q};
                        dout_valid_q <= 1'b1;
                        slot_q       <= 3'd0;
                    end else begin
                        shadow_q[slot_q] <= din;
                        slot_q           <= slot_q + 3'd1;
                    end
                end
            end
        end
    end
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign locked     = (state_q == RUN);
    assign sync_err   = sync_err_q;
endmodule

// File: tb/tb_demux_8_tdm.sv
// tb_demux_8_tdm: directed frames checked every cycle against a word-list model of the framing rules.
module tb_demux_8_tdm;
    localparam int W = 1;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           frame_sync = 1'b0;
    logic [8*W-1:0] dout;
    logic           dout_valid;
    logic [2:0]     slot;
    logic           locked;
    logic           sync_err;
    int             n_chk = 0;
    int             n_fail = 0;

    demux_8_tdm #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .dout(dout), .dout_valid(dout_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    logic [W-1:0]   m_words [8];
    int             m_cnt;
    bit             m_locked, m_dv, m_err;
    logic [8*W-1:0] m_dout;

    // model: a frame is the list of words collected since the last accepted sync
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_locked = 0; m_dv = 0; m_err = 0; m_dout = '0;
        end else begin
            m_dv = 0; m_err = 0;
            if (din_valid) begin
                if (frame_sync) begin
                    m_err = m_locked && m_cnt != 0;
                    m_words[0] = din; m_cnt = 1; m_locked = 1;
                end else if (m_locked) begin
                    if (m_cnt == 0) begin
                        m_err = 1; m_locked = 0;
                    end else begin
                        m_words[m_cnt] = din;
                        m_cnt++;
                        if (m_cnt == 8) begin
                            for (int k = 0; k < 8; k++) m_dout[k*W +: W] = m_words[k];
                            m_dv = 1; m_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("dout", 64'(dout), 64'(m_dout));
        chk("dout_valid", 64'(dout_valid), 64'(m_dv));
        chk("slot", 64'(slot), 64'(m_cnt));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("sync_err", 64'(sync_err), 64'(m_err));
    end

    task automatic word(input logic d, input logic fs);
        @(negedge clk);
        din = W'(d); din_valid = 1'b1; frame_sync = fs;
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0; frame_sync = 1'b1; din = '1;
    endtask

    task automatic frame(input logic [7:0] p, input int gap);
        for (int i = 0; i < 8; i++) begin
            word(p[i], i == 0);
            repeat (gap) idle();
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_slot", 64'(slot), 64'd0);
        chk("rst_dv", 64'(dout_valid), 64'd0);
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("init_dout", 64'(dout), 64'd0);
        chk("init_locked", 64'(locked), 64'd0);
        rst_n = 1'b1;
        idle();
        // basic frame 1,0,1,1,0,0,1,0
        frame(8'b01001101, 0);
        idle();
        chk("basic_dv", 64'(dout_valid), 64'd1);
        chk("basic_dout", 64'(dout), 64'h4D);
        chk("basic_locked", 64'(locked), 64'd1);
        idle();
        chk("basic_dv_off", 64'(dout_valid), 64'd0);
        // unsynced words before the frame are ignored
        pulse_reset();
        word(1, 0); word(1, 0); word(1, 0);
        idle();
        chk("hunt_locked", 64'(locked), 64'd0);
        frame(8'b01001101, 0);
        idle();
        chk("hunt_dout", 64'(dout), 64'h4D);
        // back-to-back frames
        frame(8'hA5, 0);
        frame(8'h3C, 0);
        idle();
        chk("b2b_dout", 64'(dout), 64'h3C);
        // early sync on word 4, then a full frame from there
        word(0, 1); word(1, 0); word(1, 0); word(1, 0);
        word(0, 1);
        idle();
        chk("early_err", 64'(sync_err), 64'd1);
        chk("early_dout_hold", 64'(dout), 64'h3C);
        frame(8'b10010110, 0);
        idle();
        chk("early_dout", 64'(dout), 64'h96);
        // lost alignment after a complete frame
        frame(8'h5A, 0);
        word(1, 0);
        idle();
        chk("lost_err", 64'(sync_err), 64'd1);
        chk("lost_locked", 64'(locked), 64'd0);
        chk("lost_dout", 64'(dout), 64'h5A);
        // gapped frame with frame_sync high while din_valid low
        frame(8'b01001101, 2);
        idle();
        chk("gap_dout", 64'(dout), 64'h4D);
        // reset mid-frame after word 5
        for (int i = 0; i < 6; i++) word(1'(i), i == 0);
        pulse_reset();
        frame(8'hE1, 0);
        idle();
        chk("post_rst_dout", 64'(dout), 64'hE1);
        repeat (3) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
